// File: rtl/vector_gather.sv
// Purpose: gathers a stream of signed samples into a NumIn-lane vector for a downstream adder tree.
// Latency: vector valid the cycle after its last lane is accepted; one bubble cycle per vector.
// Backpressure: input stalls (in_ready_o low) while a vector is held awaiting vec_ready_i.
// Optional: define VECTOR_GATHER_LAST_EN to let in_last_i close a vector early.
module vector_gather #(
  parameter  int InWidth  = 16,
  parameter  int NumIn    = 9,
  localparam int CntWidth = $clog2(NumIn + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic signed [InWidth-1:0] in_data_i,
  input  logic                      in_last_i,
  output logic                      vec_valid_o,
  input  logic                      vec_ready_i,
  output logic signed [InWidth-1:0] vec_o [NumIn],
  output logic [CntWidth-1:0]       vec_count_o
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(NumIn - 1);

  state_e                    state_q, state_d;
  logic [CntWidth-1:0]       idx_q, idx_d;
  logic [CntWidth-1:0]       cnt_q, cnt_d;
  logic signed [InWidth-1:0] lane_q [NumIn];
  logic signed [InWidth-1:0] lane_d [NumIn];

  logic accept;
  logic close_now;

  assign accept = in_valid_i & in_ready_o;

`ifdef VECTOR_GATHER_LAST_EN
  // A sample closes the vector if it fills the last lane or is flagged last.
  assign close_now = accept & ((idx_q == LastIdx) | in_last_i);
`else
  // in_last_i is kept on the port for drop-in compatibility but has no effect.
  logic unused_last;
  assign unused_last = in_last_i;
  assign close_now   = accept & (idx_q == LastIdx);
`endif

  // State register: FILL out of reset so the first sample is accepted on release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: close on the final lane, release on the downstream handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (close_now)   state_d = HOLD;
      HOLD:    if (vec_ready_i) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Outputs decoded purely from the state register, no combinational paths from inputs.
  always_comb begin
    in_ready_o  = (state_q == FILL);
    vec_valid_o = (state_q == HOLD);
  end

  // Datapath next values: write the indexed lane while filling, clear everything on handshake.
  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NumIn; i++) begin
      lane_d[i] = lane_q[i];
    end
    if (state_q == FILL) begin
      if (accept) begin
        for (int i = 0; i < NumIn; i++) begin
          if (idx_q == CntWidth'(i)) begin
            lane_d[i] = in_data_i;
          end
        end
        idx_d = idx_q + CntWidth'(1);
        if (close_now) begin
          cnt_d = idx_q + CntWidth'(1);
        end
      end
    end else if (vec_ready_i) begin
      // Clearing lanes here is what keeps unwritten lanes of a short vector at zero.
      idx_d = '0;
      cnt_d = '0;
      for (int i = 0; i < NumIn; i++) begin
        lane_d[i] = '0;
      end
    end
  end

  // Datapath registers: reset discards any partial or pending vector.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < NumIn; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < NumIn; i++) begin
        lane_q[i] <= lane_d[i];
      end
    end
  end

  // Present the held lanes and their count directly from the registers.
  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      vec_o[i] = lane_q[i];
    end
    vec_count_o = cnt_q;
  end

endmodule

// File: tb/tb_vector_gather.sv
// Directed bench for vector_gather: a 9-lane/16-bit instance and a 1-lane instance.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Expected values are written out by hand in each directed step.
module tb_vector_gather;

  logic clk;
  logic rst;

  // 9-lane instance
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               in_last;
  logic               vec_valid;
  logic               vec_ready;
  logic signed [15:0] vec [9];
  logic [3:0]         vec_count;

  // 1-lane instance
  logic               in_valid1;
  logic               in_ready1;
  logic signed [15:0] in_data1;
  logic               in_last1;
  logic               vec_valid1;
  logic               vec_ready1;
  logic signed [15:0] vec1 [1];
  logic [0:0]         vec_count1;

  int n_checks;
  int n_fail;
  int exp_v [9];

  vector_gather #(.InWidth(16), .NumIn(9)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .vec_valid_o (vec_valid),
    .vec_ready_i (vec_ready),
    .vec_o       (vec),
    .vec_count_o (vec_count)
  );

  vector_gather #(.InWidth(16), .NumIn(1)) dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid1),
    .in_ready_o  (in_ready1),
    .in_data_i   (in_data1),
    .in_last_i   (in_last1),
    .vec_valid_o (vec_valid1),
    .vec_ready_i (vec_ready1),
    .vec_o       (vec1),
    .vec_count_o (vec_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare every lane against exp_v and the lane count against cnt.
  task automatic check_vec(input string tag, input int cnt);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("%s.lane%0d", tag, i), 32'(vec[i]), exp_v[i]);
    end
    chk({tag, ".count"}, {28'd0, vec_count}, cnt);
  endtask

  task automatic send(input int d, input logic last);
    in_valid = 1'b1;
    in_data  = d[15:0];
    in_last  = last;
    step();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    vec_ready = 1'b0;
    in_valid1 = 1'b0;
    in_data1  = '0;
    in_last1  = 1'b0;
    vec_ready1 = 1'b0;

    // Reset state
    step();
    step();
    chk("rst.in_ready", {31'd0, in_ready}, 1);
    chk("rst.vec_valid", {31'd0, vec_valid}, 0);
    exp_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_vec("rst", 0);
    chk("rst1.in_ready", {31'd0, in_ready1}, 1);
    chk("rst1.vec_valid", {31'd0, vec_valid1}, 0);
    rst = 1'b0;

    // Full vector back-to-back with downstream always ready
    vec_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("full.in_ready%0d", k), {31'd0, in_ready}, 1);
      chk($sformatf("full.vec_valid%0d", k), {31'd0, vec_valid}, 0);
      send(k, 1'b0);
    end
    chk("full.vec_valid", {31'd0, vec_valid}, 1);
    chk("full.in_ready_bubble", {31'd0, in_ready}, 0);
    exp_v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    check_vec("full", 9);
    send(99, 1'b0);  // handshake cycle: this sample must not be taken
    in_valid = 1'b0;
    chk("full.after.vec_valid", {31'd0, vec_valid}, 0);
    chk("full.after.in_ready", {31'd0, in_ready}, 1);
    exp_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_vec("full.after", 0);

    // Backpressure in HOLD with a sample waiting
    vec_ready = 1'b0;
    for (int k = 0; k < 9; k++) send(21 + k, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h7FFF;
    exp_v = '{21, 22, 23, 24, 25, 26, 27, 28, 29};
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp%0d.vec_valid", c), {31'd0, vec_valid}, 1);
      chk($sformatf("bp%0d.in_ready", c), {31'd0, in_ready}, 0);
      check_vec($sformatf("bp%0d", c), 9);
    end
    vec_ready = 1'b1;
    step();
    chk("bp.release.in_ready", {31'd0, in_ready}, 1);
    chk("bp.release.lane0", 32'(vec[0]), 0);
    vec_ready = 1'b0;  // ignored while filling
    step();
    chk("bp.next.lane0", 32'(vec[0]), 32767);
    chk("bp.next.lane1", 32'(vec[1]), 0);
    chk("bp.next.vec_valid", {31'd0, vec_valid}, 0);

    // Reset mid-vector after four accepted samples
    send(31, 1'b0);
    send(32, 1'b0);
    send(33, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst.in_ready", {31'd0, in_ready}, 1);
    chk("midrst.vec_valid", {31'd0, vec_valid}, 0);
    exp_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_vec("midrst", 0);
    step();
    rst = 1'b0;
    for (int k = 10; k <= 18; k++) send(k, 1'b0);
    in_valid = 1'b0;
    chk("postrst.vec_valid", {31'd0, vec_valid}, 1);
    exp_v = '{10, 11, 12, 13, 14, 15, 16, 17, 18};
    check_vec("postrst", 9);
    vec_ready = 1'b1;
    step();
    chk("postrst.done", {31'd0, vec_valid}, 0);

    // Early close via in_last
    send(-3, 1'b0);
    send(4, 1'b0);
    send(5, 1'b1);
`ifdef VECTOR_GATHER_LAST_EN
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("early.vec_valid", {31'd0, vec_valid}, 1);
    exp_v = '{-3, 4, 5, 0, 0, 0, 0, 0, 0};
    check_vec("early", 3);
    step();
    chk("early.done", {31'd0, vec_valid}, 0);
    // in_last on the final lane closes exactly one vector
    for (int k = 1; k <= 9; k++) send(k * 2, (k == 9));
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("lastfull.vec_valid", {31'd0, vec_valid}, 1);
    exp_v = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
    check_vec("lastfull", 9);
    step();
    chk("lastfull.done", {31'd0, vec_valid}, 0);
    chk("lastfull.idle_count", {28'd0, vec_count}, 0);
`else
    in_last = 1'b0;
    for (int k = 6; k <= 11; k++) begin
      chk($sformatf("nolast.vec_valid%0d", k), {31'd0, vec_valid}, 0);
      chk($sformatf("nolast.in_ready%0d", k), {31'd0, in_ready}, 1);
      send(k, 1'b0);
    end
    in_valid = 1'b0;
    chk("nolast.vec_valid", {31'd0, vec_valid}, 1);
    exp_v = '{-3, 4, 5, 6, 7, 8, 9, 10, 11};
    check_vec("nolast", 9);
    step();
    chk("nolast.done", {31'd0, vec_valid}, 0);
`endif

    // Single-lane instance: every accepted sample is its own vector
    vec_ready1 = 1'b1;
    in_valid1  = 1'b1;
    in_data1   = -16'sd1;
    step();
    chk("n1.v0.vec_valid", {31'd0, vec_valid1}, 1);
    chk("n1.v0.lane0", 32'(vec1[0]), -1);
    chk("n1.v0.count", {31'd0, vec_count1}, 1);
    in_data1 = 16'sd2;
    step();
    chk("n1.bubble.vec_valid", {31'd0, vec_valid1}, 0);
    chk("n1.bubble.in_ready", {31'd0, in_ready1}, 1);
    step();
    in_valid1 = 1'b0;
    chk("n1.v1.vec_valid", {31'd0, vec_valid1}, 1);
    chk("n1.v1.lane0", 32'(vec1[0]), 2);
    chk("n1.v1.count", {31'd0, vec_count1}, 1);
    step();
    chk("n1.done", {31'd0, vec_valid1}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
